// File: rtl/modmul_by_2k_pkg.sv
// Shared types and default constants for the modmul_by_2k slice.
package modmul_by_2k_pkg;

  localparam int          DEFAULT_LOGQ = 64;
  localparam logic [63:0] DEFAULT_Q    = 64'd18446744069414584321;
  localparam int          DEFAULT_KW   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/modmul_by_2k_double_step.sv
// One combinational modular doubling: y = 2a mod q, for a < q.
module mod_double_step #(
  parameter int LOGQ = 64
) (
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] q,
  output logic [LOGQ-1:0] y
);

  logic [LOGQ:0] dbl;
  logic [LOGQ:0] q_ext;
  logic [LOGQ:0] red;

  // One extra bit holds 2a, which can reach 2q-2.
  assign dbl   = {a, 1'b0};
  assign q_ext = {1'b0, q};
  assign red   = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
  assign y     = red[LOGQ-1:0];

endmodule

// File: rtl/modmul_by_2k.sv
// Iterative x*2^k mod q: one modular doubling per RUN cycle.
// Define MODMUL_BY_2K_FIXED_Q_EN to use parameter Q as the modulus instead of the q port.
module modmul_by_2k
  import modmul_by_2k_pkg::*;
#(
  parameter int              LOGQ = DEFAULT_LOGQ,
  parameter logic [LOGQ-1:0] Q    = LOGQ'(DEFAULT_Q),
  parameter int              KW   = DEFAULT_KW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ntt,
  input  logic [KW-1:0]   k,
  input  logic [LOGQ-1:0] x,
  input  logic [LOGQ-1:0] q,
  output logic            busy,
  output logic            done,
  output logic [LOGQ-1:0] y
);

  state_t          state_reg;
  logic [LOGQ-1:0] acc_reg;
  logic [KW-1:0]   cnt_reg;
  logic [KW-1:0]   k_eff;
  logic [LOGQ-1:0] mod_q;
  logic [LOGQ-1:0] acc_next;

`ifdef MODMUL_BY_2K_FIXED_Q_EN
  logic unused_q_port;
  assign mod_q         = Q;
  assign unused_q_port = ^q;
`else
  logic [LOGQ-1:0] q_reg;
  logic            unused_q_param;
  assign mod_q          = q_reg;
  assign unused_q_param = ^Q;
`endif

  assign k_eff = ntt ? k : '0;

  mod_double_step #(.LOGQ(LOGQ)) u_step (
    .a (acc_reg),
    .q (mod_q),
    .y (acc_next)
  );

  // IDLE and DONE accept start identically, so DONE can chain without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      y         <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
`ifndef MODMUL_BY_2K_FIXED_Q_EN
      q_reg     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc_reg <= x;
`ifndef MODMUL_BY_2K_FIXED_Q_EN
            q_reg   <= q;
`endif
            if (k_eff == '0) begin
              state_reg <= ST_DONE;
              y         <= x;
              done      <= 1'b1;
              busy      <= 1'b0;
              cnt_reg   <= '0;
            end else begin
              state_reg <= ST_RUN;
              busy      <= 1'b1;
              cnt_reg   <= k_eff;
            end
          end else begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg - 1'b1;
          // Last doubling lands directly in y so done coincides with valid data.
          if (cnt_reg == KW'(1)) begin
            state_reg <= ST_DONE;
            y         <= acc_next;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_by_2k.sv
// Self-checking bench for modmul_by_2k: timing/value model plus directed literal cases.
module tb_modmul_by_2k;

  localparam logic [63:0] FQ = 64'hFFFF_FFFF_0000_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ntt = 1'b0;
  logic [5:0]  k = '0;
  logic [63:0] x = '0;
  logic [63:0] q = 64'd17;
  logic        busy, done;
  logic [63:0] y;

  int tests = 0;
  int fails = 0;

  modmul_by_2k dut (
    .clk(clk), .reset(reset), .start(start), .ntt(ntt), .k(k),
    .x(x), .q(q), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Modulus the DUT actually uses, and the value to drive on the q port.
  function automatic logic [63:0] mod_of(input logic [63:0] qv);
`ifdef MODMUL_BY_2K_FIXED_Q_EN
    return FQ;
`else
    return qv;
`endif
  endfunction

  function automatic logic [63:0] qdrv(input logic [63:0] qv);
`ifdef MODMUL_BY_2K_FIXED_Q_EN
    return 64'd0;
`else
    return qv;
`endif
  endfunction

  // Reference: x * 2^k mod m in wide arithmetic.
  function automatic logic [63:0] model(input logic [63:0] xv, input logic [63:0] mv, input int kv);
    logic [127:0] r;
    r = ({64'd0, xv} << kv) % {64'd0, mv};
    return r[63:0];
  endfunction

  // Compare process: operation accepted at edge t0 must show busy on edges t0..t0+k-1
  // and done with the result on edge t0+k; y holds between results.
  int          edge_n = 0;
  bit          pend = 0;
  int          t_done = 0;
  logic [63:0] res = '0;
  logic [63:0] exp_y = '0;
  bit          exp_busy = 0, exp_done = 0;

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      pend = 0; exp_y = '0; exp_busy = 0; exp_done = 0;
    end else begin
      if (!(pend && (edge_n - 1) < t_done) && start) begin
        pend   = 1;
        t_done = edge_n + (ntt ? int'(k) : 0);
        res    = model(x, mod_of(q), ntt ? int'(k) : 0);
      end
      exp_busy = pend && (edge_n < t_done);
      exp_done = pend && (edge_n == t_done);
      if (exp_done) exp_y = res;
    end
    #1;
    chk("cyc_busy", {63'd0, busy}, {63'd0, exp_busy});
    chk("cyc_done", {63'd0, done}, {63'd0, exp_done});
    chk("cyc_y", y, exp_y);
  end

  // Directed operation: edges counted including the start-sampling edge.
  task automatic op(input string nm, input logic [63:0] xv, input logic [63:0] qv, input int kv,
                    input bit nv, input logic [63:0] ey, input int eedges, input int ebusy);
    int n, nb;
    @(negedge clk);
    x = xv; q = qdrv(qv); k = 6'(kv); ntt = nv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 1; nb = int'(busy);
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++; nb += int'(busy);
    end
    $display("[TB] op %s x=%0h k=%0d ntt=%0d -> y=%0h after %0d edges", nm, xv, kv, nv, y, n);
    chk({nm, "_edges"}, 64'(n), 64'(eedges));
    chk({nm, "_y"}, y, ey);
    chk({nm, "_busycnt"}, 64'(nb), 64'(ebusy));
  endtask

  initial begin
    int n;
    logic [63:0] qv, m, xr;

    #2 reset = 1'b1;
    #1;
    chk("rst_y", y, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    chk("model_pin_a", model(64'd9, 64'd17, 4), 64'd8);
    chk("model_pin_b", model(64'd3, 64'd17, 2), 64'd12);

`ifdef MODMUL_BY_2K_FIXED_Q_EN
    op("fixq", FQ - 64'd1, FQ, 1, 1'b1, 64'hFFFF_FFFE_FFFF_FFFF, 2, 1);
`else
    op("k1", 64'd9, 64'd17, 1, 1'b1, 64'd1, 2, 1);
    op("k4", 64'd9, 64'd17, 4, 1'b1, 64'd8, 5, 4);
    op("k0", 64'd9, 64'd17, 0, 1'b1, 64'd9, 1, 0);
    op("ntt0", 64'd9, 64'd17, 4, 1'b0, 64'd9, 1, 0);
    op("bigq", FQ - 64'd1, FQ, 1, 1'b1, 64'hFFFF_FFFE_FFFF_FFFF, 2, 1);

    // Abort mid-RUN with reset, then a normal operation.
    @(negedge clk);
    x = 64'd9; q = 64'd17; k = 6'd5; ntt = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("abort_y", y, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (6) @(negedge clk);
    op("after_rst", 64'd3, 64'd17, 2, 1'b1, 64'd12, 3, 2);

    // Start during RUN is ignored; start held in DONE chains back-to-back.
    @(negedge clk);
    x = 64'd5; q = 64'd17; k = 6'd3; ntt = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; n = 1;
    @(negedge clk);
    x = 64'd1; k = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n++;
    x = 64'd2; q = 64'd17; k = 6'd1;
    while (!done && n < 100) begin @(posedge clk); #1 n++; end
    $display("[TB] op ignore x=5 k=3 -> y=%0h after %0d edges", y, n);
    chk("ignore_edges", 64'(n), 64'd4);
    chk("ignore_y", y, 64'd6);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0; n = 1;
    while (!done && n < 100) begin @(posedge clk); #1 n++; end
    $display("[TB] op b2b x=2 k=1 -> y=%0h after %0d edges", y, n);
    chk("b2b_edges", 64'(n), 64'd2);
    chk("b2b_y", y, 64'd4);
`endif

    // Random stream: inputs churn every cycle, including while RUN.
    repeat (3000) begin
      @(negedge clk);
      qv = {$urandom, $urandom} | 64'd1;
      if (qv < 64'd3) qv = 64'd3;
      if ($urandom_range(0, 3) == 0) qv = 64'd17;
      m  = mod_of(qv);
      xr = {$urandom, $urandom} % m;
      if ($urandom_range(0, 7) == 0) xr = m - 64'd1;
      x = xr; q = qv;
      ntt   = ($urandom_range(0, 4) != 0);
      k     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 5));
      start = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk) start = 1'b0;
    repeat (80) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/modmul_by_2k.md
MODMUL_BY_2K -- requirements
Module: modmul_by_2k

Interface
REQ-001 Parameter LOGQ, default 64: coefficient and modulus width in bits.
REQ-002 Parameter Q, default 64'd18446744069414584321: fixed modulus, used only when fixed-Q mode is compiled in.
REQ-003 Parameter KW, default 6: width of the shift-count input k.
REQ-004 clk  input  1: single clock; all state is updated on the rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: request pulse; sampled only while idle or in DONE.
REQ-007 ntt  input  1: 1 computes x*2^k mod q; 0 passes x through unchanged (treated as k=0).
REQ-008 k  input  KW: number of modular doublings.
REQ-009 x  input  LOGQ: operand; caller guarantees x < q.
REQ-010 q  input  LOGQ: modulus; odd, q >= 3, MSB-aligned to LOGQ.
REQ-011 busy  output  1: high in RUN.
REQ-012 done  output  1: one-cycle pulse when y becomes valid.
REQ-013 y  output  LOGQ: result, held stable from done until the next accepted start.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE, encoded 2 bits.
- IDLE with start: latch x, q, k (k forced to 0 if ntt=0).
- k=0: go to DONE.
- k>0: go to RUN.
REQ-015 Each RUN cycle SHALL do acc <= (2*acc >= q) ? 2*acc - q : 2*acc, computed in LOGQ+1 bits, and decrement the counter.
- When the counter reaches 0, go to DONE.
REQ-016 Latency SHALL be exactly k+1 rising edges from the start-sampling edge to done high, for every k in 0..2^KW-1.
REQ-017 In DONE, done=1 for exactly one cycle and y <= acc; next state is IDLE, or RUN/DONE if start is asserted (back-to-back accept, no bubble).
REQ-018 start in RUN SHALL be ignored: no latch, no state change, no error.
REQ-019 y SHALL always be < q, given x < q.
REQ-020 x, q, k and ntt changing during RUN SHALL NOT affect the result.

Reset
REQ-021 reset=1 SHALL immediately force: state IDLE, busy=0, done=0, y=0, acc=0, counter=0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release is handled normally.

Configuration
REQ-023 Macro MODMUL_BY_2K_FIXED_Q_EN defined: the modulus SHALL be parameter Q, the q port is ignored and the q register is removed.
REQ-024 Macro not defined: the modulus SHALL be the q value latched at start.

Structure
REQ-025 The shared package SHALL hold:
- the state enum (IDLE/RUN/DONE);
- the default LOGQ, Q and KW constants.
REQ-026 Sub-module mod_double_step SHALL implement one combinational modular doubling (inputs a, q; output (2a mod q)), instantiated once.
REQ-027 The datapath SHALL be one accumulator register, one down-counter and one output register; there is no shiftreg delay line.

Verification
REQ-028 q=17, x=9, k=1, ntt=1 -> done after 2 edges, y=1.
REQ-029 q=17, x=9, k=4 -> busy for 4 cycles, done at edge 5, y=8 (steps 1,2,4,8).
REQ-030 q=17, x=9, k=0 or ntt=0 -> done 1 edge after start, y=9, busy never high.
REQ-031 q=0xFFFFFFFF00000001, x=q-1, k=1 -> y=0xFFFFFFFEFFFFFFFF (q-2); fixed-Q build gives the same result with q port tied to 0.
REQ-032 Start k=5, assert reset at the 3rd RUN cycle -> outputs all 0 at once, no done; then start x=3,q=17,k=2 -> y=12 after 3 edges.
REQ-033 Start k=3, re-pulse start with new x during RUN -> ignored, original result delivered; start held in DONE -> new operation accepted back-to-back.
